// File: rtl/newton_diff_if.sv
// Sample-in / coefficient-out bundle between the sample buffer and the difference engine.
// Latency: none, this is only wiring.
// Backpressure: in_valid/in_ready on the sample side and out_valid/out_ready on the coefficient side.
interface newton_diff_if #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 4
);
   logic             start;
   logic [IDX_W-1:0] n_pts;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             busy;
   logic             err_cfg;
   logic [2:0]       err_flags;

   modport master (
      output start, n_pts, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy, err_cfg, err_flags
   );

   modport slave (
      input  start, n_pts, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, busy, err_cfg, err_flags
   );
endinterface

// File: rtl/newton_diff_engine.sv
// Purpose: load n samples, compute the leading forward differences D^k y0 in place, stream them out.
// Latency: last sample handshake to first out_valid is n(n-1)/2 + 1 cycles (one subtract per cycle).
// Backpressure: in_ready only in LOAD; out_valid/out_data hold while out_ready is low; stalls only stretch.

// IEEE754 half-precision adder, round-to-nearest-even, with overflow/NaN/inexact flags.
module float_adder (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum,
   output logic        overflow,
   output logic        nan,
   output logic        precision_lost
);
   logic        a_nan, b_nan, a_inf, b_inf, swap, sx, sy, found, rup;
   logic [15:0] x, y;
   logic [4:0]  xe, ye, d;
   logic [10:0] mx, my, mant;
   logic [27:0] al;
   logic [13:0] yal, n;
   logic [14:0] s;
   logic [6:0]  e;
   logic [3:0]  lz, sh;
   logic [11:0] m;

   // Align the smaller operand, add/subtract magnitudes, normalise, round, then patch specials.
   always_comb begin
      n     = '0;
      sh    = '0;
      a_nan = (&a[14:10]) && (|a[9:0]);
      b_nan = (&b[14:10]) && (|b[9:0]);
      a_inf = (&a[14:10]) && !(|a[9:0]);
      b_inf = (&b[14:10]) && !(|b[9:0]);
      // larger magnitude goes to x so the magnitude subtract never goes negative
      swap  = b[14:0] > a[14:0];
      x     = swap ? b : a;
      y     = swap ? a : b;
      sx    = x[15];
      sy    = y[15];
      xe    = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
      ye    = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
      mx    = {|x[14:10], x[9:0]};
      my    = {|y[14:10], y[9:0]};
      d     = xe - ye;
      // three guard bits plus a sticky bit folded into the LSB
      al    = {my, 17'b0} >> ((d > 5'd27) ? 5'd27 : d);
      yal   = {al[27:15], |al[14:0]};
      if (sx == sy) s = {1'b0, mx, 3'b000} + {1'b0, yal};
      else          s = {1'b0, mx, 3'b000} - {1'b0, yal};
      e     = {2'b00, xe};
      lz    = '0;
      found = 1'b0;
      for (int i = 13; i >= 0; i--) begin
         if (!found) begin
            if (s[i]) found = 1'b1;
            else      lz = lz + 4'd1;
         end
      end
      if (s[14]) begin
         n = {s[14:2], s[1] | s[0]};
         e = e + 7'd1;
      end else begin
         // never shift below the minimum exponent: that leaves a subnormal
         sh = ({3'b000, lz} > (e - 7'd1)) ? (e[3:0] - 4'd1) : lz;
         n  = s[13:0] << sh;
         e  = e - {3'b000, sh};
      end
      rup = n[2] && (n[1] || n[0] || n[3]);
      m   = {1'b0, n[13:3]} + {11'b0, rup};
      if (m[11]) begin
         mant = m[11:1];
         e    = e + 7'd1;
      end else begin
         mant = m[10:0];
      end
      sum            = {sx, (mant[10] ? e[4:0] : 5'd0), mant[9:0]};
      overflow       = 1'b0;
      nan            = 1'b0;
      precision_lost = |n[2:0];
      if (s == 15'd0) sum = {sx & sy, 15'd0};
      if (e >= 7'd31) begin
         sum      = {sx, 5'h1f, 10'h000};
         overflow = 1'b1;
      end
      if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
         sum            = 16'h7e00;
         nan            = 1'b1;
         overflow       = 1'b0;
         precision_lost = 1'b0;
      end else if (a_inf || b_inf) begin
         sum            = {(a_inf ? a[15] : b[15]), 5'h1f, 10'h000};
         overflow       = 1'b0;
         precision_lost = 1'b0;
      end
   end
endmodule

module newton_diff_engine #(
   parameter int DEPTH   = 8,
   parameter int IDX_W   = 4,
   parameter int FP_MODE = 1,
   parameter int WIDTH   = 16
) (
   input  logic         clk,
   input  logic         rst,
   newton_diff_if.slave bus
);
   localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);
   localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
   localparam logic [IDX_W-1:0] TWO     = IDX_W'(2);

   typedef enum logic [1:0] {IDLE, LOAD, CALC, EMIT} state_t;
   state_t state, state_nx;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0] n_r, w_r, p_r, i_r, k_r, n_last;
   logic [AW-1:0]    prev_idx;
   logic [2:0]       err_flags_r, sub_flags;
   logic             err_cfg_r, cfg_ok, job_go, ld_fire, calc_end;
   logic [WIDTH-1:0] rd_a, rd_b, sub_res;

   assign n_last   = n_r - ONE;
   assign prev_idx = i_r[AW-1:0] - AW'(1);
   assign rd_a     = mem[i_r[AW-1:0]];
   assign rd_b     = mem[prev_idx];

   if (FP_MODE != 0) begin : g_fp
      logic [15:0] fa_sum;
      logic        fa_ovf, fa_nan, fa_pl;
      float_adder u_fa (
         .a              (rd_a),
         .b              ({~rd_b[15], rd_b[14:0]}),
         .sum            (fa_sum),
         .overflow       (fa_ovf),
         .nan            (fa_nan),
         .precision_lost (fa_pl)
      );
      assign sub_res   = fa_sum;
      assign sub_flags = {fa_nan, fa_ovf, fa_pl};
   end else begin : g_int
      logic [WIDTH-1:0] diff;
      assign diff      = rd_a - rd_b;
      assign sub_res   = diff;
      assign sub_flags = {1'b0, (rd_a[WIDTH-1] != rd_b[WIDTH-1]) && (diff[WIDTH-1] != rd_a[WIDTH-1]), 1'b0};
   end

   // State register; reset aborts any job in flight.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode and the handshake qualifiers used by the datapath.
   always_comb begin
      state_nx = state;
      cfg_ok   = (bus.n_pts >= TWO) && (bus.n_pts <= DEPTH_I);
      job_go   = 1'b0;
      ld_fire  = 1'b0;
      calc_end = 1'b0;
      case (state)
         IDLE: begin
            job_go = bus.start && cfg_ok;
            if (job_go) state_nx = LOAD;
         end
         LOAD: begin
            ld_fire = bus.in_valid;
            if (ld_fire && (w_r == n_last)) state_nx = CALC;
         end
         CALC: begin
            calc_end = (p_r == n_last) && (i_r == p_r);
            if (calc_end) state_nx = EMIT;
         end
         EMIT: begin
            if (bus.out_ready && (k_r == n_last)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Job counters and flags: write pointer, pass/index walk, emit index, sticky errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_r         <= '0;
         w_r         <= '0;
         p_r         <= '0;
         i_r         <= '0;
         k_r         <= '0;
         err_flags_r <= '0;
         err_cfg_r   <= 1'b0;
      end else begin
         err_cfg_r <= (state == IDLE) && bus.start && !cfg_ok;
         case (state)
            IDLE: begin
               if (job_go) begin
                  n_r         <= bus.n_pts;
                  w_r         <= '0;
                  p_r         <= ONE;
                  i_r         <= bus.n_pts - ONE;
                  k_r         <= '0;
                  err_flags_r <= '0;
               end
            end
            LOAD: begin
               if (ld_fire) w_r <= w_r + ONE;
            end
            CALC: begin
               err_flags_r <= err_flags_r | sub_flags;
               // walk i downwards so mem[i-1] still holds the previous pass value
               if (i_r == p_r) begin
                  p_r <= p_r + ONE;
                  i_r <= n_last;
               end else begin
                  i_r <= i_r - ONE;
               end
            end
            EMIT: begin
               if (bus.out_ready) k_r <= k_r + ONE;
            end
            default: ;
         endcase
      end
   end

   // Sample/difference storage; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == LOAD && ld_fire) mem[w_r[AW-1:0]] <= bus.in_data;
         else if (state == CALC)       mem[i_r[AW-1:0]] <= sub_res;
      end
   end

   assign bus.in_ready  = (state == LOAD);
   assign bus.out_valid = (state == EMIT);
   assign bus.out_data  = (state == EMIT) ? mem[k_r[AW-1:0]] : '0;
   assign bus.out_last  = (state == EMIT) && (k_r == n_last);
   assign bus.busy      = (state != IDLE);
   assign bus.err_cfg   = err_cfg_r;
   assign bus.err_flags = err_flags_r;
endmodule

// File: tb/tb_newton_diff_engine.sv
module tb_newton_diff_engine;
   localparam int DEPTH = 8;
   localparam int IDX_W = 4;
   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [IDX_W-1:0] n_pts;
   logic             in_valid;
   logic [15:0]      in_data;
   logic             out_ready;
   logic             use_int;

   int nvec = 0;
   int nerr = 0;

   logic [15:0] job_in   [16];
   logic [15:0] job_out  [16];
   logic        job_last [16];
   int          calc_cyc, lat, stall_bad;
   bit          timeout;

   always #5 clk = ~clk;

   newton_diff_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) fb ();
   newton_diff_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) ib ();

   assign fb.start = start;    assign ib.start = start;
   assign fb.n_pts = n_pts;    assign ib.n_pts = n_pts;
   assign fb.in_valid = in_valid;   assign ib.in_valid = in_valid;
   assign fb.in_data = in_data;     assign ib.in_data = in_data;
   assign fb.out_ready = out_ready; assign ib.out_ready = out_ready;

   newton_diff_engine #(.DEPTH(DEPTH), .IDX_W(IDX_W), .FP_MODE(1), .WIDTH(WIDTH)) u_fp (
      .clk (clk), .rst (rst), .bus (fb)
   );
   newton_diff_engine #(.DEPTH(DEPTH), .IDX_W(IDX_W), .FP_MODE(0), .WIDTH(WIDTH)) u_int (
      .clk (clk), .rst (rst), .bus (ib)
   );

   wire        o_in_ready  = use_int ? ib.in_ready  : fb.in_ready;
   wire        o_out_valid = use_int ? ib.out_valid : fb.out_valid;
   wire [15:0] o_out_data  = use_int ? ib.out_data  : fb.out_data;
   wire        o_out_last  = use_int ? ib.out_last  : fb.out_last;
   wire        o_busy      = use_int ? ib.busy      : fb.busy;
   wire        o_err_cfg   = use_int ? ib.err_cfg   : fb.err_cfg;
   wire [2:0]  o_err_flags = use_int ? ib.err_flags : fb.err_flags;

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; n_pts = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // start a job, load job_in[0..n-1], wait out CALC, drain n coefficients
   task automatic run_job(input int n, input bit toggle);
      int j, g, k;
      bit hs, held, phase;
      logic [15:0] pd;
      logic pl;
      timeout = 0; stall_bad = 0; calc_cyc = 0;
      start = 1'b1; n_pts = IDX_W'(n);
      @(posedge clk); #1;
      start = 1'b0;
      j = 0; g = 0;
      while (j < n && g < 200) begin
         in_valid = 1'b1; in_data = job_in[j]; hs = o_in_ready;
         @(posedge clk); #1; g++;
         if (hs) j++;
      end
      in_valid = 1'b0;
      if (j < n) timeout = 1;
      g = 0;
      while (!o_out_valid && g < 500) begin
         if (o_busy && !o_in_ready) calc_cyc++;
         @(posedge clk); #1; g++;
      end
      lat = g + 1;
      k = 0; g = 0; phase = 1; held = 0; pd = '0; pl = 1'b0;
      while (k < n && g < 500) begin
         out_ready = toggle ? phase : 1'b1;
         phase = ~phase;
         if (held && (o_out_data !== pd || o_out_last !== pl)) stall_bad++;
         held = o_out_valid && !out_ready; pd = o_out_data; pl = o_out_last;
         if (o_out_valid && out_ready) begin
            job_out[k] = o_out_data; job_last[k] = o_out_last; k++;
         end
         @(posedge clk); #1; g++;
      end
      out_ready = 1'b0;
      if (k < n) timeout = 1;
   endtask

   task automatic test_reset();
      do_reset();
      nvec++; if (fb.busy !== 1'b0)      begin nerr++; $display("FAIL reset_busy: got %b want 0", fb.busy); end
      nvec++; if (fb.in_ready !== 1'b0)  begin nerr++; $display("FAIL reset_in_ready: got %b want 0", fb.in_ready); end
      nvec++; if (fb.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", fb.out_valid); end
      nvec++; if (fb.out_last !== 1'b0)  begin nerr++; $display("FAIL reset_out_last: got %b want 0", fb.out_last); end
      nvec++; if (fb.out_data !== 16'h0) begin nerr++; $display("FAIL reset_out_data: got %h want 0000", fb.out_data); end
      nvec++; if (fb.err_cfg !== 1'b0)   begin nerr++; $display("FAIL reset_err_cfg: got %b want 0", fb.err_cfg); end
      nvec++; if (fb.err_flags !== 3'b0) begin nerr++; $display("FAIL reset_err_flags: got %b want 000", fb.err_flags); end
      nvec++; if (ib.busy !== 1'b0)      begin nerr++; $display("FAIL reset_int_busy: got %b want 0", ib.busy); end
   endtask

   task automatic test_fp_table6();
      logic [15:0] yv [6];
      logic [15:0] ev [6];
      yv = '{16'h0000, 16'h3c00, 16'h4900, 16'h53e0, 16'h5d10, 16'h65cd};
      ev = '{16'h0000, 16'h3c00, 16'h4800, 16'h5080, 16'h5800, 16'h5e40};
      use_int = 1'b0;
      for (int i = 0; i < 6; i++) job_in[i] = yv[i];
      run_job(6, 1'b0);
      nvec++; if (timeout) begin nerr++; $display("FAIL fp6_timeout: got 1 want 0"); end
      for (int i = 0; i < 6; i++) begin
         nvec++;
         if (job_out[i] !== ev[i]) begin nerr++; $display("FAIL fp6_out[%0d]: got %h want %h", i, job_out[i], ev[i]); end
         nvec++;
         if (job_last[i] !== (i == 5)) begin nerr++; $display("FAIL fp6_last[%0d]: got %b want %b", i, job_last[i], (i == 5)); end
      end
      nvec++; if (calc_cyc != 15) begin nerr++; $display("FAIL fp6_calc_cycles: got %0d want 15", calc_cyc); end
      nvec++; if (lat != 16)      begin nerr++; $display("FAIL fp6_latency: got %0d want 16", lat); end
      nvec++; if (o_err_flags !== 3'b000) begin nerr++; $display("FAIL fp6_flags: got %b want 000", o_err_flags); end
      nvec++; if (o_out_valid !== 1'b0 || o_busy !== 1'b0)
         begin nerr++; $display("FAIL fp6_back_idle: got valid=%b busy=%b want 0 0", o_out_valid, o_busy); end
   endtask

   task automatic test_int_backpressure();
      logic [15:0] ev [4];
      ev = '{16'd1, 16'd3, 16'd2, 16'd0};
      use_int = 1'b1;
      job_in[0] = 16'd1; job_in[1] = 16'd4; job_in[2] = 16'd9; job_in[3] = 16'd16;
      run_job(4, 1'b1);
      nvec++; if (timeout) begin nerr++; $display("FAIL int4_timeout: got 1 want 0"); end
      for (int i = 0; i < 4; i++) begin
         nvec++;
         if (job_out[i] !== ev[i]) begin nerr++; $display("FAIL int4_out[%0d]: got %h want %h", i, job_out[i], ev[i]); end
         nvec++;
         if (job_last[i] !== (i == 3)) begin nerr++; $display("FAIL int4_last[%0d]: got %b want %b", i, job_last[i], (i == 3)); end
      end
      nvec++; if (stall_bad != 0) begin nerr++; $display("FAIL int4_stall_hold: got %0d unstable cycles want 0", stall_bad); end
      nvec++; if (lat != 7)       begin nerr++; $display("FAIL int4_latency: got %0d want 7", lat); end
      use_int = 1'b0;
   endtask

   task automatic test_nan_then_clean();
      use_int = 1'b0;
      job_in[0] = 16'h3c00; job_in[1] = 16'h7e00; job_in[2] = 16'h4000;
      run_job(3, 1'b0);
      nvec++; if (timeout) begin nerr++; $display("FAIL nan_timeout: got 1 want 0"); end
      nvec++; if (o_err_flags !== 3'b100) begin nerr++; $display("FAIL nan_flags: got %b want 100", o_err_flags); end
      job_in[0] = 16'h3c00; job_in[1] = 16'h4000;
      run_job(2, 1'b0);
      nvec++; if (timeout) begin nerr++; $display("FAIL clean_timeout: got 1 want 0"); end
      nvec++; if (o_err_flags !== 3'b000) begin nerr++; $display("FAIL clean_flags: got %b want 000", o_err_flags); end
      nvec++; if (job_out[0] !== 16'h3c00) begin nerr++; $display("FAIL clean_out0: got %h want 3c00", job_out[0]); end
      nvec++; if (job_out[1] !== 16'h3c00) begin nerr++; $display("FAIL clean_out1: got %h want 3c00", job_out[1]); end
   endtask

   task automatic test_overflow();
      use_int = 1'b0;
      job_in[0] = 16'h7bff; job_in[1] = 16'hfbff;
      run_job(2, 1'b0);
      nvec++; if (timeout) begin nerr++; $display("FAIL ovf_timeout: got 1 want 0"); end
      nvec++; if (job_out[0] !== 16'h7bff) begin nerr++; $display("FAIL ovf_out0: got %h want 7bff", job_out[0]); end
      nvec++; if (job_out[1] !== 16'hfc00) begin nerr++; $display("FAIL ovf_out1: got %h want fc00", job_out[1]); end
      nvec++; if (o_err_flags !== 3'b010) begin nerr++; $display("FAIL ovf_flags: got %b want 010", o_err_flags); end
   endtask

   task automatic test_err_cfg();
      int pulses, bz, ir;
      use_int = 1'b0;
      for (int t = 0; t < 2; t++) begin
         pulses = 0; bz = 0; ir = 0;
         start = 1'b1; n_pts = (t == 0) ? IDX_W'(1) : IDX_W'(DEPTH + 1);
         @(posedge clk); #1;
         start = 1'b0;
         for (int c = 0; c < 4; c++) begin
            if (o_err_cfg) pulses++;
            if (o_busy) bz++;
            if (o_in_ready) ir++;
            @(posedge clk); #1;
         end
         nvec++; if (pulses != 1) begin nerr++; $display("FAIL cfg%0d_pulses: got %0d want 1", t, pulses); end
         nvec++; if (bz != 0)     begin nerr++; $display("FAIL cfg%0d_busy: got %0d cycles want 0", t, bz); end
         nvec++; if (ir != 0)     begin nerr++; $display("FAIL cfg%0d_in_ready: got %0d cycles want 0", t, ir); end
      end
      nvec++; if (o_err_flags !== 3'b010) begin nerr++; $display("FAIL cfg_flags_kept: got %b want 010", o_err_flags); end
   endtask

   task automatic test_reset_mid_calc();
      logic [15:0] sq [8];
      int j, g;
      sq = '{16'h0000, 16'h3c00, 16'h4400, 16'h4880, 16'h4c00, 16'h4e40, 16'h5080, 16'h5220};
      use_int = 1'b0;
      start = 1'b1; n_pts = IDX_W'(DEPTH);
      @(posedge clk); #1;
      start = 1'b0;
      j = 0; g = 0;
      while (j < DEPTH && g < 200) begin
         in_valid = 1'b1; in_data = sq[j];
         @(posedge clk); #1; g++; j++;
      end
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      nvec++; if (o_busy !== 1'b1 || o_in_ready !== 1'b0)
         begin nerr++; $display("FAIL abort_in_calc: got busy=%b in_ready=%b want 1 0", o_busy, o_in_ready); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      nvec++; if (o_busy !== 1'b0)      begin nerr++; $display("FAIL abort_busy: got %b want 0", o_busy); end
      nvec++; if (o_out_valid !== 1'b0) begin nerr++; $display("FAIL abort_out_valid: got %b want 0", o_out_valid); end
      for (int i = 0; i < DEPTH; i++) job_in[i] = sq[i];
      run_job(DEPTH, 1'b0);
      nvec++; if (timeout) begin nerr++; $display("FAIL sq8_timeout: got 1 want 0"); end
      for (int i = 0; i < DEPTH; i++) begin
         logic [15:0] ev;
         ev = (i == 1) ? 16'h3c00 : (i == 2) ? 16'h4000 : 16'h0000;
         nvec++;
         if (job_out[i] !== ev) begin nerr++; $display("FAIL sq8_out[%0d]: got %h want %h", i, job_out[i], ev); end
      end
      nvec++; if (calc_cyc != 28) begin nerr++; $display("FAIL sq8_calc_cycles: got %0d want 28", calc_cyc); end
   endtask

   initial begin
      use_int = 1'b0;
      test_reset();
      test_fp_table6();
      test_int_backpressure();
      test_nan_then_clean();
      test_overflow();
      test_err_cfg();
      test_reset_mid_calc();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
